// File: rtl/de10_lite_sopc_mul_seq_combiner.sv
// Sequencer and result stage for the 16x16 three-partial multiply cell: handshakes a 32x32
// request in, drives the cell, and combines p1/p2/p3 into the low 32 bits of the product.
// Optional macro MUL_COMBINE_PIPE_EN splits the combine add over two cycles (COMB, COMB2).
module de10_lite_sopc_mul_seq_combiner #(
    parameter int MUL_LATENCY = 1,
    parameter int CNT_W       = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    output logic        mul_en,
    input  logic [31:0] mul_p1,
    input  logic [31:0] mul_p2,
    input  logic [31:0] mul_p3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_MUL   = 3'd1;
    localparam logic [2:0] ST_COMB  = 3'd2;
    localparam logic [2:0] ST_COMB2 = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LATENCY - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      src1_q, src1_d;
    logic [31:0]      src2_q, src2_d;
    logic [31:0]      result_q, result_d;
    logic             accept;

    // Upper halves of the cross partials only affect bits above 31 of the product.
    logic             unused_hi;
    assign unused_hi = ^{mul_p2[31:16], mul_p3[31:16]};

`ifdef MUL_COMBINE_PIPE_EN
    logic [15:0] mid_q, mid_d;
    logic [31:0] p1_q, p1_d;
`endif

    // Ready in DONE only when the current product is being taken the same cycle.
    assign req_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && rsp_ready);
    assign accept     = req_valid && req_ready;
    assign mul_en     = (state_q == ST_MUL);
    assign rsp_valid  = (state_q == ST_DONE);
    assign mul_src1   = src1_q;
    assign mul_src2   = src2_q;
    assign rsp_result = result_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        result_d = result_q;
`ifdef MUL_COMBINE_PIPE_EN
        mid_d    = mid_q;
        p1_d     = p1_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d = ST_MUL;
                    cnt_d   = '0;
                    src1_d  = req_src1;
                    src2_d  = req_src2;
                end else if (state_q == ST_DONE && rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_COMB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COMB: begin
`ifdef MUL_COMBINE_PIPE_EN
                mid_d   = mul_p2[15:0] + mul_p3[15:0];
                p1_d    = mul_p1;
                state_d = ST_COMB2;
`else
                result_d = mul_p1 + {mul_p2[15:0], 16'h0} + {mul_p3[15:0], 16'h0};
                state_d  = ST_DONE;
`endif
            end
            ST_COMB2: begin
`ifdef MUL_COMBINE_PIPE_EN
                result_d = p1_q + {mid_q, 16'h0};
                state_d  = ST_DONE;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over any simultaneous handshake; the last result is left in place.
        if (flush) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            src1_d   = src1_q;
            src2_d   = src2_q;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            result_q <= result_d;
        end
    end

`ifdef MUL_COMBINE_PIPE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mid_q <= '0;
            p1_q  <= '0;
        end else begin
            mid_q <= mid_d;
            p1_q  <= p1_d;
        end
    end
`endif

endmodule

// File: tb/tb_de10_lite_sopc_mul_seq_combiner.sv
// Self-checking bench for de10_lite_sopc_mul_seq_combiner: models the multiply cell,
// runs directed cases then randomized traffic against a 64-bit arithmetic reference.
module tb_de10_lite_sopc_mul_seq_combiner;

    localparam int LAT = 1;
`ifdef MUL_COMBINE_PIPE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    // Edges from the accept edge until rsp_valid is seen high.
    localparam int RSP_EDGES = LAT + 1 + EXTRA;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_src1 = '0;
    logic [31:0] req_src2 = '0;
    logic [31:0] mul_src1, mul_src2;
    logic        mul_en;
    logic [31:0] mul_p1, mul_p2, mul_p3;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;

    int checks = 0;
    int errors = 0;
    int txn = 0;

    always #5 clk = ~clk;

    de10_lite_sopc_mul_seq_combiner #(.MUL_LATENCY(LAT), .CNT_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2),
        .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_en(mul_en),
        .mul_p1(mul_p1), .mul_p2(mul_p2), .mul_p3(mul_p3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result)
    );

    // Behavioural cell: LAT enabled register stages of the three 16x16 partials.
    logic [31:0] pa [LAT];
    logic [31:0] pb [LAT];
    logic [31:0] pc [LAT];
    always @(posedge clk) begin
        if (mul_en) begin
            pa[0] <= {16'h0, mul_src1[15:0]} * {16'h0, mul_src2[15:0]};
            pb[0] <= {16'h0, mul_src1[15:0]} * {16'h0, mul_src2[31:16]};
            pc[0] <= {16'h0, mul_src1[31:16]} * {16'h0, mul_src2[15:0]};
            for (int i = 1; i < LAT; i++) begin
                pa[i] <= pa[i-1];
                pb[i] <= pb[i-1];
                pc[i] <= pc[i-1];
            end
        end
    end
    assign mul_p1 = pa[LAT-1];
    assign mul_p2 = pb[LAT-1];
    assign mul_p3 = pc[LAT-1];

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'h0, a} * {32'h0, b};
        return full[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request in a cycle where req_ready is expected high; returns one edge later.
    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_src1  = a;
        req_src2  = b;
        #1;
        chk("accept_ready", {31'h0, req_ready}, 32'h1);
        tick();
        req_valid = 1'b0;
        req_src1  = $urandom;
        req_src2  = $urandom;
        chk("mul_en_after_accept", {31'h0, mul_en}, 32'h1);
        chk("mul_src1_latched", mul_src1, a);
        chk("mul_src2_latched", mul_src2, b);
    endtask

    task automatic wait_rsp(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (!rsp_valid && n < 64) begin
            tick();
            n++;
        end
        chk("rsp_latency", n, RSP_EDGES);
        chk("rsp_result", rsp_result, ref_mul(a, b));
        $display("TXN %0d a=%h b=%h result=%h latency_edges=%0d", txn, a, b, rsp_result, n);
        txn++;
    endtask

    // Stalls the product for 'stall' cycles (with a decoy request), then takes it,
    // optionally issuing the next request in the same cycle.
    task automatic respond(input int stall, input bit b2b, input logic [31:0] na, input logic [31:0] nb);
        logic [31:0] held;
        held = rsp_result;
        for (int s = 0; s < stall; s++) begin
            req_valid = 1'b1;
            req_src1  = $urandom;
            req_src2  = $urandom;
            #1;
            chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
            tick();
            chk("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("stall_result", rsp_result, held);
            chk("stall_mul_en", {31'h0, mul_en}, 32'h0);
        end
        req_valid = b2b;
        req_src1  = na;
        req_src2  = nb;
        rsp_ready = 1'b1;
        #1;
        chk("done_ready", {31'h0, req_ready}, 32'h1);
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("rsp_drop", {31'h0, rsp_valid}, 32'h0);
        if (b2b) begin
            chk("b2b_mul_en", {31'h0, mul_en}, 32'h1);
            chk("b2b_src1", mul_src1, na);
            chk("b2b_src2", mul_src2, nb);
        end else begin
            chk("idle_ready", {31'h0, req_ready}, 32'h1);
        end
    endtask

    initial begin
        logic [31:0] a, b, na, nb;
        bit          b2b;
        bit          inflight;

        for (int i = 0; i < LAT; i++) begin
            pa[i] = '0;
            pb[i] = '0;
            pc[i] = '0;
        end

        // Reset state.
        tick();
        tick();
        reset_n = 1'b1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_mul_en", {31'h0, mul_en}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_result", rsp_result, 32'h0);
        chk("rst_src1", mul_src1, 32'h0);
        chk("rst_src2", mul_src2, 32'h0);
        tick();

        // Basic product and latency.
        accept(32'h0001_0003, 32'h0002_0005);
        wait_rsp(32'h0001_0003, 32'h0002_0005);
        chk("t1_value", rsp_result, 32'h000B_000F);
        respond(0, 1'b0, 32'h0, 32'h0);

        // All-ones wrap.
        accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_rsp(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("t2_value", rsp_result, 32'h0000_0001);
        // Five-cycle stall, then back-to-back 7*6.
        respond(5, 1'b1, 32'd7, 32'd6);
        wait_rsp(32'd7, 32'd6);
        chk("t4_value", rsp_result, 32'h0000_002A);
        respond(0, 1'b0, 32'h0, 32'h0);

        // Flush in MUL with rsp_ready high.
        accept(32'h1234_5678, 32'h9ABC_DEF0);
        flush     = 1'b1;
        rsp_ready = 1'b1;
        tick();
        flush     = 1'b0;
        rsp_ready = 1'b0;
        chk("flush_ready", {31'h0, req_ready}, 32'h1);
        chk("flush_mul_en", {31'h0, mul_en}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("flush_no_rsp", {31'h0, rsp_valid}, 32'h0);
            tick();
        end
        accept(32'd2, 32'd3);
        wait_rsp(32'd2, 32'd3);
        chk("t5_value", rsp_result, 32'h6);
        respond(0, 1'b0, 32'h0, 32'h0);

        // Asynchronous reset while combining.
        accept(32'hDEAD_BEEF, 32'h0BAD_F00D);
        repeat (LAT) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("arst_mul_en", {31'h0, mul_en}, 32'h0);
        chk("arst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("arst_result", rsp_result, 32'h0);
        chk("arst_src1", mul_src1, 32'h0);
        #1;
        reset_n = 1'b1;
        tick();
        chk("arst_idle_after", {31'h0, rsp_valid}, 32'h0);

        // Randomized traffic with stalls, idle gaps and back-to-back requests.
        inflight = 1'b0;
        a = 32'h0;
        b = 32'h0;
        for (int i = 0; i < 40; i++) begin
            if (!inflight) begin
                repeat ($urandom_range(0, 2)) tick();
                a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                b = ($urandom_range(0, 7) == 0) ? 32'h0000_FFFF : $urandom;
                accept(a, b);
            end
            wait_rsp(a, b);
            na  = $urandom;
            nb  = $urandom;
            b2b = ($urandom_range(0, 1) == 1) && (i < 39);
            respond($urandom_range(0, 3), b2b, na, nb);
            inflight = b2b;
            a = na;
            b = nb;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
